// File: rtl/ctrl_pkt_gen_pkg.sv
// Shared definitions for the control-packet generator: header template,
// field positions, target-block encodings, request-entry layout and FSM states.
package ctrl_pkt_gen_pkg;

    localparam int CTRL_DATA_W = 512;
    localparam int ENTRY_W     = 276;

    // UDP destination port that marks a frame as a control packet
    localparam logic [15:0] CTRL_UDP_PORT = 16'hF1F2;

    // Length value carried in tuser[15:0] of the header beat
    localparam logic [15:0] HDR_TUSER_LEN = 16'd128;

    // Ethernet / IPv4 / UDP header, first byte on the wire in tdata[511:504]
    localparam logic [CTRL_DATA_W-1:0] CTRL_HDR = {
        48'h0253_4446_0001,                 // Ethernet destination
        48'h0253_4446_0000,                 // Ethernet source
        16'h0800,                           // EtherType IPv4
        8'h45, 8'h00, 16'd62,               // version/IHL, DSCP, total length
        16'h0000, 16'h4000,                 // identification, flags/fragment
        8'h40, 8'h11, 16'h0000,             // TTL, protocol UDP, checksum
        32'hC0A8_0001, 32'hC0A8_0002,       // source / destination address
        16'hF1F1, CTRL_UDP_PORT,            // UDP source / destination port
        16'd42, 16'h0000,                   // UDP length, checksum
        176'd0
    };

    // Per-packet fields overlaid on the header beat
    localparam int HDR_MOD_LSB = 328;
    localparam int HDR_SEQ_LSB = 336;

    // Field positions in the payload beat
    localparam int PAY_DATA_LSB = 0;
    localparam int PAY_IDX_LSB  = 256;
    localparam int PAY_RES_LSB  = 264;
    localparam int PAY_MOD_LSB  = 268;

    // Target block encodings
    localparam logic [7:0] MOD_PARSER   = 8'd0;
    localparam logic [7:0] MOD_STAGE1   = 8'd1;
    localparam logic [7:0] MOD_STAGE2   = 8'd2;
    localparam logic [7:0] MOD_STAGE3   = 8'd3;
    localparam logic [7:0] MOD_STAGE4   = 8'd4;
    localparam logic [7:0] MOD_STAGE5   = 8'd5;
    localparam logic [7:0] MOD_DEPARSER = 8'd6;

    // One buffered table-write request (276 bits, payload-beat order)
    typedef struct packed {
        logic [7:0]   module_id;
        logic [3:0]   resource_id;
        logic [7:0]   index;
        logic [255:0] data;
    } req_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2
    } state_e;

endpackage

// File: rtl/ctrl_req_fifo.sv
// First-word-fall-through request buffer; the head entry is always on dout.
module ctrl_req_fifo
    import ctrl_pkt_gen_pkg::*;
#(
    parameter int WIDTH = ENTRY_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Storage array; contents are don't-care while empty, so it is not reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; simultaneous push and pop keep the count
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_pkt_gen.sv
// Turns buffered table-write requests into 2-beat control packets on an
// AXI-Stream master: a header beat followed by a payload beat.
module ctrl_pkt_gen
    import ctrl_pkt_gen_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int REQ_FIFO_DEPTH       = 4
) (
    input  logic                              clk,
    input  logic                              aresetn,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [7:0]                        req_module_id,
    input  logic [3:0]                        req_resource_id,
    input  logic [7:0]                        req_index,
    input  logic [255:0]                      req_data,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
    output logic                              c_m_axis_tvalid,
    output logic                              c_m_axis_tlast,
    input  logic                              c_m_axis_tready,
    output logic [31:0]                       pkt_sent_cnt
);

    state_e     state;
    state_e     state_next;
    req_entry_t head;
    req_entry_t entry_q;
    req_entry_t req_entry;
    logic [7:0] seq;
    logic [7:0] hdr_seq;
    logic       fifo_full;
    logic       fifo_empty;
    logic       hs;
    logic       pop;
    logic       load_hdr;
    logic       load_pay;
    logic       pkt_done;
    logic       go_idle;
    logic [C_S_AXIS_DATA_WIDTH-1:0] hdr_word;
    logic [C_S_AXIS_DATA_WIDTH-1:0] pay_word;

    // Ready depends only on the registered FIFO occupancy, held low in reset
    assign req_ready = aresetn && !fifo_full;
    assign hs        = c_m_axis_tvalid && c_m_axis_tready;

    assign req_entry.module_id   = req_module_id;
    assign req_entry.resource_id = req_resource_id;
    assign req_entry.index       = req_index;
    assign req_entry.data        = req_data;

    ctrl_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (REQ_FIFO_DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .aresetn (aresetn),
        .push    (req_valid && req_ready),
        .din     (req_entry),
        .pop     (pop),
        .dout    (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!aresetn) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Next state and beat-load strobes; a finished packet chains straight into the next header
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load_hdr   = 1'b0;
        load_pay   = 1'b0;
        pkt_done   = 1'b0;
        go_idle    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    load_hdr   = 1'b1;
                    state_next = ST_HDR;
                end
            end
            ST_HDR: begin
                if (hs) begin
                    load_pay   = 1'b1;
                    state_next = ST_PAY;
                end
            end
            ST_PAY: begin
                if (hs) begin
                    pkt_done = 1'b1;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        load_hdr   = 1'b1;
                        state_next = ST_HDR;
                    end else begin
                        go_idle    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A header loaded on the same edge as a payload handshake must already carry the bumped seq
    assign hdr_seq = pkt_done ? seq + 8'd1 : seq;

    // Beat images: header template with per-packet overlays, and the zero-padded payload
    always_comb begin
        hdr_word = CTRL_HDR;
        hdr_word[HDR_MOD_LSB +: 8] = head.module_id;
        hdr_word[HDR_SEQ_LSB +: 8] = hdr_seq;
        pay_word = '0;
        pay_word[PAY_DATA_LSB +: 256] = entry_q.data;
        pay_word[PAY_IDX_LSB  +: 8]   = entry_q.index;
        pay_word[PAY_RES_LSB  +: 4]   = entry_q.resource_id;
        pay_word[PAY_MOD_LSB  +: 8]   = entry_q.module_id;
    end

    // Registered stream outputs; they only change on a load, so they hold while stalled
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            c_m_axis_tvalid <= 1'b0;
            c_m_axis_tlast  <= 1'b0;
            c_m_axis_tdata  <= '0;
            c_m_axis_tkeep  <= '0;
            c_m_axis_tuser  <= '0;
            entry_q         <= '0;
        end else if (load_hdr) begin
            c_m_axis_tvalid <= 1'b1;
            c_m_axis_tlast  <= 1'b0;
            c_m_axis_tdata  <= hdr_word;
            c_m_axis_tkeep  <= '1;
            c_m_axis_tuser  <= C_S_AXIS_TUSER_WIDTH'(HDR_TUSER_LEN);
            entry_q         <= head;
        end else if (load_pay) begin
            c_m_axis_tvalid <= 1'b1;
            c_m_axis_tlast  <= 1'b1;
            c_m_axis_tdata  <= pay_word;
            c_m_axis_tkeep  <= '1;
            c_m_axis_tuser  <= '0;
        end else if (go_idle) begin
            c_m_axis_tvalid <= 1'b0;
            c_m_axis_tlast  <= 1'b0;
        end
    end

    // Sequence number and sent-packet count advance on each payload handshake
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            seq          <= 8'd0;
            pkt_sent_cnt <= 32'd0;
        end else if (pkt_done) begin
            seq          <= seq + 8'd1;
            pkt_sent_cnt <= pkt_sent_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_ctrl_pkt_gen.sv
// Bench for ctrl_pkt_gen: directed scenarios plus random traffic against a
// queue-based packet model.
`timescale 1ns/1ps
module tb_ctrl_pkt_gen;

    logic         clk = 1'b0;
    logic         aresetn;
    logic         req_valid;
    logic         req_ready;
    logic [7:0]   req_module_id;
    logic [3:0]   req_resource_id;
    logic [7:0]   req_index;
    logic [255:0] req_data;
    logic [511:0] tdata;
    logic [63:0]  tkeep;
    logic [127:0] tuser;
    logic         tvalid;
    logic         tlast;
    logic         tready;
    logic [31:0]  pkt_sent_cnt;

    always #5 clk = ~clk;

    ctrl_pkt_gen dut (
        .clk             (clk),
        .aresetn         (aresetn),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_module_id   (req_module_id),
        .req_resource_id (req_resource_id),
        .req_index       (req_index),
        .req_data        (req_data),
        .c_m_axis_tdata  (tdata),
        .c_m_axis_tkeep  (tkeep),
        .c_m_axis_tuser  (tuser),
        .c_m_axis_tvalid (tvalid),
        .c_m_axis_tlast  (tlast),
        .c_m_axis_tready (tready),
        .pkt_sent_cnt    (pkt_sent_cnt)
    );

    typedef struct packed {
        logic [7:0]   m;
        logic [3:0]   r;
        logic [7:0]   i;
        logic [255:0] d;
    } req_t;

    // Expected header frame: Ethernet / IPv4 / UDP to port F1F2, first byte at the top
    localparam logic [511:0] REF_HDR = {
        48'h0253_4446_0001, 48'h0253_4446_0000, 16'h0800,
        8'h45, 8'h00, 16'd62, 16'h0000, 16'h4000,
        8'h40, 8'h11, 16'h0000, 32'hC0A8_0001, 32'hC0A8_0002,
        16'hF1F1, 16'hF1F2, 16'd42, 16'h0000,
        176'd0
    };

    req_t         exp_q[$];
    int           n_assert = 0;
    int           n_fail = 0;
    int           pkts_done = 0;
    int           beat_idx = 0;
    int           cyc = 0;
    int           acc_cyc = 0;
    int           hdr_cyc = -100;
    int           pay_cyc = -100;
    int           hs_count = 0;
    int           hs_first = 0;
    int           hs_last = 0;
    int           last_hdr_seq = -1;
    bit           accepted = 0;
    logic         prev_stall = 1'b0;
    logic [511:0] prev_tdata;
    logic [127:0] prev_tuser;
    logic         prev_tlast;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare the stream against the model, then fold this cycle's handshakes into it
    task automatic sample();
        req_t         h;
        logic [511:0] e_data;
        logic [127:0] e_user;
        check("pkt_sent_cnt", 512'(pkt_sent_cnt), 512'(32'(pkts_done)));
        if (prev_stall) begin
            check("stall_tvalid", 512'(tvalid), 512'(1'b1));
            check("stall_tdata", tdata, prev_tdata);
            check("stall_tuser", 512'(tuser), 512'(prev_tuser));
            check("stall_tlast", 512'(tlast), 512'(prev_tlast));
        end
        if (!aresetn) begin
            exp_q.delete();
            pkts_done = 0;
            beat_idx = 0;
            prev_stall = 1'b0;
            return;
        end
        if (tvalid) begin
            if (exp_q.size() == 0) begin
                check("spurious_tvalid", 512'(tvalid), 512'(1'b0));
            end else begin
                h = exp_q[0];
                if (beat_idx == 0) begin
                    e_data = REF_HDR;
                    e_data[335:328] = h.m;
                    e_data[343:336] = 8'(pkts_done % 256);
                    e_user = 128'd128;
                end else begin
                    e_data = 512'(h);
                    e_user = '0;
                end
                check(beat_idx == 0 ? "hdr_tdata" : "pay_tdata", tdata, e_data);
                check("tuser", 512'(tuser), 512'(e_user));
                check("tlast", 512'(tlast), 512'(beat_idx == 1));
                check("tkeep", 512'(tkeep), 512'({64{1'b1}}));
                if (tready) begin
                    hs_count++;
                    if (hs_count == 1) hs_first = cyc;
                    hs_last = cyc;
                    if (beat_idx == 0) begin
                        hdr_cyc = cyc;
                        last_hdr_seq = int'(tdata[343:336]);
                        beat_idx = 1;
                    end else begin
                        pay_cyc = cyc;
                        void'(exp_q.pop_front());
                        pkts_done++;
                        beat_idx = 0;
                    end
                end
            end
        end
        prev_stall = tvalid && !tready;
        prev_tdata = tdata;
        prev_tuser = tuser;
        prev_tlast = tlast;
        if (req_valid && req_ready) begin
            exp_q.push_back({req_module_id, req_resource_id, req_index, req_data});
            acc_cyc = cyc;
            accepted = 1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        req_valid = 1'b0;
        tready = 1'b0;
        step();
        step();
        check("rst_tvalid", 512'(tvalid), 512'(1'b0));
        check("rst_tlast", 512'(tlast), 512'(1'b0));
        check("rst_tdata", tdata, 512'(0));
        check("rst_tkeep", 512'(tkeep), 512'(0));
        check("rst_tuser", 512'(tuser), 512'(0));
        check("rst_req_ready", 512'(req_ready), 512'(1'b0));
        check("rst_cnt", 512'(pkt_sent_cnt), 512'(0));
        aresetn = 1'b1;
        hdr_cyc = -100;
        pay_cyc = -100;
        hs_count = 0;
        last_hdr_seq = -1;
    endtask

    task automatic offer(input logic [7:0] m, input logic [3:0] r, input logic [7:0] i,
                         input logic [255:0] d, input int bound, output bit ok);
        req_module_id = m;
        req_resource_id = r;
        req_index = i;
        req_data = d;
        req_valid = 1'b1;
        accepted = 0;
        for (int k = 0; k < bound && !accepted; k++) step();
        req_valid = 1'b0;
        ok = accepted;
    endtask

    task automatic drain(input int bound);
        for (int k = 0; k < bound && exp_q.size() != 0; k++) step();
        check("drain_empty", 512'(exp_q.size()), 512'(0));
    endtask

    function automatic logic [255:0] rand_data();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        aresetn = 1'b0;
        req_valid = 1'b0;
        tready = 1'b0;
        req_module_id = '0;
        req_resource_id = '0;
        req_index = '0;
        req_data = '0;

        // Single request: latency and field placement
        do_reset();
        tready = 1'b1;
        offer(8'd2, 4'd1, 8'h05, {32{8'hA5}}, 10, ok);
        check("s1_accept", 512'(ok), 512'(1'b1));
        drain(20);
        check("s1_hdr_latency", 512'(hdr_cyc - acc_cyc), 512'(2));
        check("s1_pay_latency", 512'(pay_cyc - acc_cyc), 512'(3));
        check("s1_cnt", 512'(pkt_sent_cnt), 512'(1));

        // Five back-to-back requests: ten beats without a bubble
        do_reset();
        tready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            offer(8'(k), 4'(k + 3), 8'(k * 7), rand_data(), 10, ok);
            check("s2_accept", 512'(ok), 512'(1'b1));
        end
        drain(60);
        check("s2_beats", 512'(hs_count), 512'(10));
        check("s2_no_bubble", 512'(hs_last - hs_first), 512'(9));
        check("s2_cnt", 512'(pkt_sent_cnt), 512'(5));

        // Blocked output: four buffered plus one held, sixth refused until space frees
        do_reset();
        for (int k = 0; k < 6; k++) begin
            offer(8'($urandom_range(0, 6)), 4'($urandom), 8'($urandom), rand_data(), 8, ok);
            if (k < 5) check("s3_accept", 512'(ok), 512'(1'b1));
            else       check("s3_refuse", 512'(ok), 512'(1'b0));
        end
        check("s3_req_ready", 512'(req_ready), 512'(1'b0));
        check("s3_held", 512'(exp_q.size()), 512'(5));
        tready = 1'b1;
        offer(req_module_id, req_resource_id, req_index, req_data, 20, ok);
        check("s3_sixth_accept", 512'(ok), 512'(1'b1));
        drain(60);
        check("s3_cnt", 512'(pkt_sent_cnt), 512'(6));

        // Random traffic with random backpressure, including stalls on beat 0
        do_reset();
        for (int k = 0; k < 400; k++) begin
            tready = ($urandom_range(0, 9) < 6);
            req_valid = ($urandom_range(0, 3) == 0);
            req_module_id = 8'($urandom_range(0, 6));
            req_resource_id = 4'($urandom);
            req_index = 8'($urandom);
            req_data = rand_data();
            step();
        end
        req_valid = 1'b0;
        tready = 1'b1;
        drain(200);

        // Sequence wrap: the 257th packet carries seq 0
        do_reset();
        tready = 1'b1;
        for (int k = 0; k < 257; k++) begin
            offer(8'($urandom_range(0, 6)), 4'($urandom), 8'(k), rand_data(), 10, ok);
            check("s5_accept", 512'(ok), 512'(1'b1));
        end
        drain(40);
        check("s5_last_seq", 512'(last_hdr_seq), 512'(0));
        check("s5_cnt", 512'(pkt_sent_cnt), 512'(257));

        // Reset between beat 0 and beat 1 discards the packet
        do_reset();
        offer(8'd4, 4'd2, 8'h33, rand_data(), 10, ok);
        for (int k = 0; k < 10 && !tvalid; k++) step();
        check("s6_hdr_up", 512'(tvalid), 512'(1'b1));
        tready = 1'b1;
        step();
        tready = 1'b0;
        check("s6_in_pay", 512'(tlast), 512'(1'b1));
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        check("s6_tvalid_clr", 512'(tvalid), 512'(1'b0));
        check("s6_cnt_clr", 512'(pkt_sent_cnt), 512'(0));
        tready = 1'b1;
        offer(8'd6, 4'd9, 8'h44, rand_data(), 10, ok);
        check("s6_accept", 512'(ok), 512'(1'b1));
        drain(20);
        check("s6_seq", 512'(last_hdr_seq), 512'(0));
        check("s6_cnt", 512'(pkt_sent_cnt), 512'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_pkt_gen.md
CTRL_PKT_GEN -- requirements
Module: ctrl_pkt_gen

Interface
REQ-001 C_S_AXIS_DATA_WIDTH, 512, control-stream data width; only 512 is supported.
REQ-002 C_S_AXIS_TUSER_WIDTH, 128, control-stream tuser width.
REQ-003 REQ_FIFO_DEPTH, 4, request-buffer entries; power of two, at least 2.
REQ-004 clk  in  1  single clock for all logic; one clock, no other clock domains.
REQ-005 aresetn  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 req_valid  in  1  table-write request present.
REQ-007 req_ready  out  1  request accepted when req_valid and req_ready are both high.
REQ-008 req_module_id  in  8  target block (parser 0, stages 1-5, deparser 6).
REQ-009 req_resource_id  in  4  target table or RAM within the block.
REQ-010 req_index  in  8  entry address.
REQ-011 req_data  in  256  entry contents.
REQ-012 c_m_axis_tdata/tkeep/tuser/tvalid/tlast  out  512/64/128/1/1  control-packet AXI-Stream master.
REQ-013 c_m_axis_tready  in  1  downstream ready.
REQ-014 pkt_sent_cnt  out  32  count of completed control packets.

Function
REQ-015 Each accepted request SHALL produce exactly one 2-beat control packet, in acceptance order.
- Beat 0: tdata = the CTRL_HDR constant (Ethernet/IPv4/UDP header, UDP destination port 0xF1F2) with tdata[335:328] = module_id and tdata[343:336] = seq; tkeep = all ones; tuser[15:0] = 16'd128 and all other tuser bits 0; tlast = 0.
- Beat 1: tdata[255:0] = data, [263:256] = index, [267:264] = resource_id, [275:268] = module_id, all higher bits 0; tkeep = all ones; tuser = 0; tlast = 1.
REQ-016 The request buffer SHALL be a FIFO of REQ_FIFO_DEPTH entries; req_ready = !full, computed from registered state only.
REQ-017 The FSM SHALL have three states: IDLE, HDR and PAY.
- IDLE -> HDR when the FIFO is non-empty; the head entry is popped into the output register.
- HDR -> PAY on tvalid & tready.
- PAY -> HDR on tvalid & tready if the FIFO is non-empty (no bubble between packets).
- PAY -> IDLE on tvalid & tready if the FIFO is empty.
REQ-018 Latency SHALL be as follows.
- A request accepted at cycle N into an empty FIFO with the FSM in IDLE presents beat 0 with tvalid high at cycle N+2: one cycle to write the FIFO, one cycle to pop it into the output register.
- With tready held high, beat 1 is presented at N+3.
REQ-019 All c_m_axis outputs SHALL be registered; once tvalid is high, tdata/tkeep/tuser/tlast SHALL hold until tready, and tvalid SHALL NOT drop without a handshake.
REQ-020 seq SHALL be 8 bits, start at 0, increment by one after each beat-1 handshake, and wrap from 255 to 0.
REQ-021 pkt_sent_cnt SHALL increment on each beat-1 handshake and wrap from 2^32-1 to 0.
REQ-022 A FIFO push and pop in the same cycle SHALL leave the occupancy unchanged; no push is possible while full, because req_ready is low.
REQ-023 With tready held low indefinitely, the FIFO SHALL fill to REQ_FIFO_DEPTH, req_ready SHALL deassert, and no request SHALL be lost or duplicated.

Reset
REQ-024 While aresetn is low, all state SHALL clear on the clock edge.
- Reset values: FSM = IDLE, FIFO empty, seq = 0, pkt_sent_cnt = 0, c_m_axis_tvalid = 0, tlast = 0, tdata/tkeep/tuser = 0.
- req_ready = 0 while aresetn is low.
REQ-025 A reset in the middle of a packet SHALL discard both the packet in flight and all buffered requests; after reset releases, no partial packet (beat 1 without beat 0) SHALL be emitted.

Structure
REQ-026 The shared package SHALL hold CTRL_HDR, the UDP port 0xF1F2, the field bit positions, the module-id encodings and the FSM state encoding.
REQ-027 The request FIFO SHALL be one sub-module, ctrl_req_fifo: 276 bits wide, synchronous reset, first-word-fall-through.

Verification
REQ-028 The bench SHALL cover the following directed scenarios.
- Single request (module 2, resource 1, index 0x05, data 0xA5 repeated) with tready=1 -> beat 0 at N+2 with seq 0; beat 1 at N+3 carrying 0xA5 repeated in [255:0], 0x05 in [263:256], 1 in [267:264], 2 in [275:268], tlast=1; pkt_sent_cnt = 1.
- 5 requests back-to-back with tready=1 -> 10 consecutive valid beats with no bubble; seq 0..4; pkt_sent_cnt = 5.
- tready=0, 6 requests offered -> exactly 4 accepted into the FIFO, plus 1 held in the output register (5 total); req_ready=0 thereafter. Raise tready -> 5 packets in order, then the 6th request is accepted.
- Random tready toggling during beat 0 -> tdata/tuser stable while tvalid=1 and tready=0.
- 257 packets -> seq of the 257th packet = 0 (wrap).
- aresetn low for 1 cycle between beat 0 and beat 1 -> tvalid=0 the next cycle; pkt_sent_cnt = 0; next packet starts with beat 0 and seq 0.
